// File: rtl/div_radix2.sv
// 32-bit radix-2 restoring divider returning {remainder, quotient}; 32 cycles per divide, 1 for divide-by-zero.
// Optional abort input enabled by defining DIV_ANNUL_EN; otherwise annul is ignored.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t      state_q;
    logic [31:0] rem_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic [4:0]  cnt_q;
    logic        sdiv_q;
    logic        sa_q;
    logic        sb_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic        annul_act;
`ifdef DIV_ANNUL_EN
    assign annul_act = annul;
`else
    logic unused_annul;
    assign unused_annul = annul;
    assign annul_act    = 1'b0;
`endif

    logic        sa_in;
    logic        sb_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    assign sa_in = signed_div & opdata1[31];
    assign sb_in = signed_div & opdata2[31];
    assign a_mag = sa_in ? (~opdata1 + 32'd1) : opdata1;
    assign b_mag = sb_in ? (~opdata2 + 32'd1) : opdata2;

    // One restoring step: the shifted-in remainder needs 33 bits for the compare.
    logic [32:0] shl;
    logic [32:0] diff;
    logic        qbit;
    logic [31:0] rem_d;
    logic [31:0] dvd_d;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        shl     = {rem_q, dvd_q[31]};
        diff    = shl - {1'b0, dsr_q};
        qbit    = (shl >= {1'b0, dsr_q});
        rem_d   = qbit ? diff[31:0] : shl[31:0];
        dvd_d   = {dvd_q[30:0], qbit};
        quo_fix = (sdiv_q & (sa_q ^ sb_q)) ? (~dvd_d + 32'd1) : dvd_d;
        rem_fix = (sdiv_q & sa_q) ? (~rem_d + 32'd1) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            sdiv_q   <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !annul_act) begin
                        if (opdata2 == 32'd0) begin
                            state_q <= DIVZERO;
                        end else begin
                            state_q <= BUSY;
                            rem_q   <= '0;
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            cnt_q   <= '0;
                            sdiv_q  <= signed_div;
                            sa_q    <= sa_in;
                            sb_q    <= sb_in;
                        end
                    end
                end
                DIVZERO: begin
                    if (annul_act) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= DONE;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (annul_act) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q  <= DONE;
                            result_q <= {rem_fix, quo_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (annul_act || !start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: directed plan cases plus random divides against a longint reference.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    div_radix2 dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: plain integer division truncating toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return 64'h0;
        if (sd) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: every rising edge of ready consumes one expected entry.
    logic rdy_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready && !rdy_prev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready: got result=%h with nothing pending", result);
                end else begin
                    e = sb.pop_front();
                    if (result !== e.res) begin
                        bad++;
                        $display("FAIL result: got %h expected %h", result, e.res);
                    end
                    total++;
                    if (cyc - e.e0 != e.lat) begin
                        bad++;
                        $display("FAIL latency: got %0d expected %0d", cyc - e.e0, e.lat);
                    end
                end
            end
            rdy_prev = ready;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // annul_at > 0 pulses annul on that cycle of the wait; used where annul must be ignored.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b, input int annul_at);
        exp_t e;
        int   n;
        @(negedge clk);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        e.res = model(sd, a, b);
        e.e0  = cyc + 1;
        e.lat = (b == 32'd0) ? 1 : 32;
        sb.push_back(e);
        n = 0;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
            annul = (n == annul_at);
            if (n > 2) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
        end
        annul = 1'b0;
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL timeout: ready=%b after %0d cycles, required 1", ready, n);
            void'(sb.pop_back());
        end
        start = 1'b0;
        @(negedge clk);
        check("ready_drop", {63'b0, ready}, 64'h0);
        check("result_hold", result, e.res);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [63:0] prev;
        int          rises;
        repeat (3) @(negedge clk);
        check("reset_ready", {63'b0, ready}, 64'h0);
        check("reset_result", result, 64'h0);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, -1);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, -1);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, -1);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, -1);
        do_div(1'b0, 32'h1234, 32'd0, -1);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, -1);

        // Reset mid-division must clear result and ready.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (11) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("midreset_ready", {63'b0, ready}, 64'h0);
        check("midreset_result", result, 64'h0);
        rst = 1'b0;

        do_div(1'b0, 32'd1000, 32'd3, -1);

`ifdef DIV_ANNUL_EN
        prev = result;
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (6) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        rises = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) rises++;
        end
        check("annul_no_ready", 64'(rises), 64'h0);
        check("annul_result_kept", result, prev);
        do_div(1'b0, 32'd9, 32'd4, -1);
`else
        prev  = 64'h0;
        rises = 0;
        do_div(1'b0, 32'd1000, 32'd3, 6);
        do_div(1'b0, 32'd9, 32'd4, -1);
`endif

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 20);
                3:       b = 32'd0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            do_div(1'($urandom_range(0, 1)), a, b, -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
